// File: rtl/jtkicker_colmix_pkg.sv
// Shared helpers for the multi-layer colour mixer: parameter legality
// checks, priority search order and packed-RGB bit expansion.
package jtkicker_colmix_pkg;

    // Widest colour component the expansion helper can produce
    localparam int EXPW = 16;

    // Legal layer count, transparency width and pipeline depth
    function automatic bit params_ok(input int layers, input int pxlw,
                                     input int transw, input int blank_dly);
        return (layers >= 2) && (layers <= 4) && (transw >= 1) &&
               (transw <= pxlw) && (blank_dly >= 2);
    endfunction

    // Output width must hold every packed field and fit the expander
    function automatic bit outw_ok(input int outw, input int rw,
                                   input int gw, input int bw);
        return (outw >= rw) && (outw >= gw) && (outw >= bw) && (outw <= EXPW) &&
               (rw >= 1) && (gw >= 1) && (bw >= 1);
    endfunction

    // Layer examined at a given search slot; slots run from layers-1 down
    // to 1. With swap the two topmost layers trade places. With only two
    // layers the backdrop stays at the bottom, so swap has no effect.
    function automatic int slot_layer(input int layers, input int slot,
                                      input logic swap);
        if (swap && (layers >= 3) && (slot == layers - 1)) begin
            return layers - 2;
        end else if (swap && (layers >= 3) && (slot == layers - 2)) begin
            return layers - 1;
        end else begin
            return slot;
        end
    endfunction

    // Left-align a w-bit field in outw bits and fill the low bits by
    // repeating the field from its MSB (abc -> abca, ab -> abab).
    function automatic logic [EXPW-1:0] expand(input logic [EXPW-1:0] field,
                                               input int w, input int outw);
        logic [2*EXPW-1:0] acc;
        int                bits;
        acc  = {(2*EXPW){1'b0}};
        bits = 0;
        for (int n = 0; n < EXPW; n++) begin
            if (bits < outw) begin
                acc  = (acc << w) | {{EXPW{1'b0}}, field};
                bits = bits + w;
            end
        end
        return EXPW'(acc >> (bits - outw));
    endfunction

endpackage

// File: rtl/jtkicker_colmix_multi_prom.sv
// Palette PROM: written from the download port on any clock, read
// synchronously on the pixel enable. Contents survive reset.
module jtframe_prom
    import jtkicker_colmix_pkg::*;
#(
    parameter int dw      = 8,
    parameter int aw      = 7,
    parameter     simfile = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic [dw-1:0] data_i,
    input  logic [aw-1:0] rd_addr_i,
    input  logic [aw-1:0] wr_addr_i,
    input  logic          we_i,
    output logic [dw-1:0] q_o
);

    logic [dw-1:0] mem_q [0:(2**aw)-1];
    logic [dw-1:0] q_q;

    // Contents arrive through the download port; the init-file name is
    // carried only so instantiations stay compatible with other cores.
    if (simfile != "") begin : g_simfile
    end

    // Download write; independent of the pixel enable
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= data_i;
        end
    end

    // Registered read; a same-cycle write to this address yields old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= {dw{1'b0}};
        end else if (cen_i) begin
            q_q <= mem_q[rd_addr_i];
        end else begin
            q_q <= q_q;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jtkicker_colmix_multi.sv
// N-layer priority colour mixer: picks the top opaque layer, looks it up
// in the palette PROM and expands it to OUTW-bit components, with the
// blanking signals delayed alongside so colour and blank stay aligned.
module jtkicker_colmix_multi
    import jtkicker_colmix_pkg::*;
#(
    parameter int LAYERS    = 3,
    parameter int PXLW      = 4,
    parameter int TRANSW    = 4,
    parameter int BANKW     = 1,
    parameter int RW        = 3,
    parameter int GW        = 3,
    parameter int BW        = 2,
    parameter int OUTW      = 4,
    parameter int BLANK_DLY = 4,
    parameter     SIMFILE   = ""
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       pxl_cen,
    input  logic [LAYERS*PXLW-1:0]                     pxl,
    input  logic [LAYERS-1:0]                          gfx_en,
    input  logic                                       prio_swap,
    input  logic [((BANKW > 0) ? BANKW : 1)-1:0]       pal_bank,
    input  logic                                       preLHBL,
    input  logic                                       preLVBL,
    input  logic [BANKW+$clog2(LAYERS)+PXLW-1:0]       prog_addr,
    input  logic [RW+GW+BW-1:0]                        prog_data,
    input  logic                                       prog_en,
    output logic [OUTW-1:0]                            red,
    output logic [OUTW-1:0]                            green,
    output logic [OUTW-1:0]                            blue,
    output logic                                       LHBL,
    output logic                                       LVBL
);

    localparam int LW = $clog2(LAYERS);
    localparam int AW = BANKW + LW + PXLW;
    localparam int DW = RW + GW + BW;
    localparam int CW = 3 * OUTW;

    if (!params_ok(LAYERS, PXLW, TRANSW, BLANK_DLY) || !outw_ok(OUTW, RW, GW, BW)) begin : g_bad_params
        $error("jtkicker_colmix_multi: illegal parameter combination");
    end

    logic [LAYERS-1:0]  opaque_s;
    logic [LW-1:0]      win_idx_s;
    logic [PXLW-1:0]    win_pxl_s;
    logic [AW-1:0]      addr_d;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      raw_s;
    logic [BLANK_DLY:1] hbl_q;
    logic [BLANK_DLY:1] vbl_q;
    logic [CW-1:0]      col_d;
    logic [CW-1:0]      col_s;

    // Per-layer opacity: enabled and low pixel bits not all zero
    always_comb begin
        opaque_s = {LAYERS{1'b0}};
        for (int k = 0; k < LAYERS; k++) begin
            opaque_s[k] = gfx_en[k] & (pxl[k*PXLW +: TRANSW] != {TRANSW{1'b0}});
        end
    end

    // Priority search from the top slot down; backdrop wins by default
    always_comb begin : winner
        logic found;
        found     = 1'b0;
        win_idx_s = {LW{1'b0}};
        win_pxl_s = gfx_en[0] ? pxl[PXLW-1:0] : {PXLW{1'b0}};
        for (int j = LAYERS - 1; j >= 1; j--) begin
            for (int k = 1; k < LAYERS; k++) begin
                if (!found && (k == slot_layer(LAYERS, j, prio_swap)) && opaque_s[k]) begin
                    found     = 1'b1;
                    win_idx_s = LW'(k);
                    win_pxl_s = pxl[k*PXLW +: PXLW];
                end else begin
                    found = found;
                end
            end
        end
    end

    if (BANKW > 0) begin : g_bank
        assign addr_d = {pal_bank[BANKW-1:0], win_idx_s, win_pxl_s};
    end else begin : g_nobank
        logic unused_bank_s;
        assign unused_bank_s = ^pal_bank;
        assign addr_d        = {win_idx_s, win_pxl_s};
    end

    // Stage 1: latch the palette address of the winning pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= {AW{1'b0}};
        end else if (pxl_cen) begin
            addr_q <= addr_d;
        end else begin
            addr_q <= addr_q;
        end
    end

    // Blanking delay line; index n holds the blank of the pixel n ticks old
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbl_q <= {BLANK_DLY{1'b0}};
            vbl_q <= {BLANK_DLY{1'b0}};
        end else if (pxl_cen) begin
            hbl_q <= {hbl_q[BLANK_DLY-1:1], preLHBL};
            vbl_q <= {vbl_q[BLANK_DLY-1:1], preLVBL};
        end else begin
            hbl_q <= hbl_q;
            vbl_q <= vbl_q;
        end
    end

    // Stage 2: palette lookup, registered inside the PROM
    jtframe_prom #(
        .dw      (DW),
        .aw      (AW),
        .simfile (SIMFILE)
    ) u_prom (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen_i     (pxl_cen),
        .data_i    (prog_data),
        .rd_addr_i (addr_q),
        .wr_addr_i (prog_addr),
        .we_i      (prog_en),
        .q_o       (raw_s)
    );

    // Expand the raw word and zero it when the same pixel's blank is active.
    // Gating here is equivalent to gating at the output since blank travels
    // in lockstep with the colour from here on.
    always_comb begin
        if (hbl_q[2] && vbl_q[2]) begin
            col_d = {OUTW'(expand(EXPW'(raw_s[RW-1:0]),       RW, OUTW)),
                     OUTW'(expand(EXPW'(raw_s[RW+GW-1:RW]),   GW, OUTW)),
                     OUTW'(expand(EXPW'(raw_s[DW-1:RW+GW]),   BW, OUTW))};
        end else begin
            col_d = {CW{1'b0}};
        end
    end

    if (BLANK_DLY == 2) begin : g_short
        assign col_s = col_d;
    end else begin : g_chain
        logic [CW-1:0] col_q [3:BLANK_DLY];

        // Colour delay line ending in the output register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 3; i <= BLANK_DLY; i++) begin
                    col_q[i] <= {CW{1'b0}};
                end
            end else if (pxl_cen) begin
                col_q[3] <= col_d;
                for (int i = 4; i <= BLANK_DLY; i++) begin
                    col_q[i] <= col_q[i-1];
                end
            end else begin
                col_q <= col_q;
            end
        end

        assign col_s = col_q[BLANK_DLY];
    end

    assign red   = col_s[CW-1 -: OUTW];
    assign green = col_s[2*OUTW-1 -: OUTW];
    assign blue  = col_s[OUTW-1:0];
    assign LHBL  = hbl_q[BLANK_DLY];
    assign LVBL  = vbl_q[BLANK_DLY];

endmodule

// File: tb/tb_jtkicker_colmix_multi.sv
// Self-checking bench for jtkicker_colmix_multi with default parameters.
module tb_jtkicker_colmix_multi;

    localparam int BLANK_DLY = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pxl_cen;
    logic [11:0] pxl;
    logic [2:0]  gfx_en;
    logic        prio_swap;
    logic [0:0]  pal_bank;
    logic        preLHBL, preLVBL;
    logic [6:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        prog_en;
    logic [3:0]  red, green, blue;
    logic        LHBL, LVBL;

    always #5 clk = ~clk;

    jtkicker_colmix_multi #(
        .LAYERS(3), .PXLW(4), .TRANSW(4), .BANKW(1), .RW(3), .GW(3), .BW(2),
        .OUTW(4), .BLANK_DLY(BLANK_DLY), .SIMFILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pxl(pxl), .gfx_en(gfx_en),
        .prio_swap(prio_swap), .pal_bank(pal_bank), .preLHBL(preLHBL), .preLVBL(preLVBL),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .red(red), .green(green), .blue(blue), .LHBL(LHBL), .LVBL(LVBL)
    );

    typedef struct {
        logic [11:0] px;
        logic [2:0]  en;
        logic        sw;
        logic        bk;
        logic        hb;
        logic        vb;
        logic [6:0]  addr;
    } vec_t;

    vec_t        tbl[12];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem_m [128];
    logic [13:0] exp_q [$];
    logic [13:0] last_exp;

    // Repeat a w-bit field MSB-first until 4 bits are filled
    function automatic int rep(input int f, input int w);
        int acc = 0;
        int bits = 0;
        while (bits < 4) begin
            acc  = acc * (1 << w) + f;
            bits = bits + w;
        end
        return acc >> (bits - 4);
    endfunction

    function automatic logic [11:0] model_rgb(input logic [7:0] d);
        int dv = int'(d);
        return 12'((rep(dv % 8, 3) << 8) | (rep((dv / 8) % 8, 3) << 4) | rep(dv / 64, 2));
    endfunction

    function automatic logic [6:0] model_addr(input logic [11:0] p, input logic [2:0] en,
                                              input logic sw, input logic bk);
        int order[2];
        int win = 0;
        int wpx = en[0] ? int'(p[3:0]) : 0;
        if (sw) begin order[0] = 1; order[1] = 2; end
        else    begin order[0] = 2; order[1] = 1; end
        for (int i = 0; i < 2; i++) begin
            int px = (int'(p) >> (4 * order[i])) % 16;
            if (en[order[i]] && px != 0) begin
                win = order[i];
                wpx = px;
                break;
            end
        end
        return 7'(int'(bk) * 64 + win * 16 + wpx);
    endfunction

    function automatic logic [13:0] outs();
        return {red, green, blue, LHBL, LVBL};
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got rgbhv=%h expected %h", nm, act, expv);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // One pixel tick, optionally with a PROM write on the same clock
    task automatic tick_ex(input logic we, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        pxl_cen = 1'b1; prog_en = we; prog_addr = a; prog_data = d;
        @(negedge clk);
        pxl_cen = 1'b0; prog_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick();
        tick_ex(1'b0, 7'd0, 8'd0);
    endtask

    task automatic prog_write(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_addr = a; prog_data = d; prog_en = 1'b1;
        @(negedge clk);
        prog_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < BLANK_DLY - 1; i++) exp_q.push_back(14'h0);
        last_exp = 14'h0;
    endtask

    task automatic set_in(input vec_t v);
        pxl = v.px; gfx_en = v.en; prio_swap = v.sw; pal_bank = v.bk;
        preLHBL = v.hb; preLVBL = v.vb;
    endtask

    // Apply one tick and compare against the expectation queued BLANK_DLY ticks ago
    task automatic step(input logic [6:0] a, input string nm);
        logic [13:0] e;
        if (preLHBL && preLVBL) e = {model_rgb(mem_m[a]), 2'b11};
        else                    e = {12'h000, preLHBL, preLVBL};
        exp_q.push_back(e);
        tick();
        last_exp = exp_q.pop_front();
        check(nm, outs(), last_exp);
    endtask

    initial begin
        int first_low, low_cnt, bad_rgb, vlow;

        tbl[0]  = '{12'h555, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 7'h25};
        tbl[1]  = '{12'h070, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 7'h17};
        tbl[2]  = '{12'h370, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 7'h23};
        tbl[3]  = '{12'h370, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 7'h17};
        tbl[4]  = '{12'h370, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 7'h40};
        tbl[5]  = '{12'h900, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 7'h29};
        tbl[6]  = '{12'h00A, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 7'h0A};
        tbl[7]  = '{12'h073, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 7'h03};
        tbl[8]  = '{12'h555, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 7'h25};
        tbl[9]  = '{12'h555, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 7'h55};
        tbl[10] = '{12'h504, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1, 7'h04};
        tbl[11] = '{12'h555, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 7'h25};

        rst_n = 1'b0; pxl_cen = 1'b0; pxl = 12'h0; gfx_en = 3'b0; prio_swap = 1'b0;
        pal_bank = 1'b0; preLHBL = 1'b0; preLVBL = 1'b0;
        prog_addr = 7'h0; prog_data = 8'h0; prog_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", outs(), 14'h0);
        rst_n = 1'b1;

        // Load the palette with random data, fixed value at 0x25
        for (int a = 0; a < 128; a++) begin
            prog_write(7'(a), (a == 'h25) ? 8'b10_011_101 : 8'($urandom));
        end

        // Latency: first colour exactly BLANK_DLY ticks after first pixel
        do_reset();
        set_in(tbl[0]);
        repeat (3) tick();
        check("latency_tick3", outs(), 14'h0);
        tick();
        check("latency_tick4", outs(), {4'hB, 4'h6, 4'hA, 2'b11});

        // Table vectors through the reference queue, then flush
        do_reset();
        foreach (tbl[i]) begin
            set_in(tbl[i]);
            step(tbl[i].addr, "table");
        end
        for (int i = 0; i < BLANK_DLY; i++) step(tbl[11].addr, "table_flush");

        // No pixel enable: nothing moves even with new inputs
        set_in(tbl[9]);
        repeat (8) @(negedge clk);
        check("stall_no_cen", outs(), last_exp);

        // Horizontal blank window of 10 ticks
        do_reset();
        set_in(tbl[0]);
        repeat (6) tick();
        first_low = -1; low_cnt = 0; bad_rgb = 0; vlow = 0;
        for (int t = 1; t <= 24; t++) begin
            preLHBL = (t <= 10) ? 1'b0 : 1'b1;
            tick();
            if (LHBL == 1'b0) begin
                if (first_low < 0) first_low = t;
                low_cnt++;
                if ({red, green, blue} != 12'h0) bad_rgb++;
            end
            if (LVBL == 1'b0) vlow++;
        end
        check_int("hblank_start_tick", first_low, 4);
        check_int("hblank_length", low_cnt, 10);
        check_int("hblank_rgb_nonzero", bad_rgb, 0);
        check_int("vblank_spurious", vlow, 0);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [11:0] p;
            for (int k = 0; k < 3; k++) begin
                p[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            pxl = p;
            gfx_en    = 3'($urandom_range(0, 7));
            prio_swap = 1'($urandom_range(0, 1));
            pal_bank  = 1'($urandom_range(0, 1));
            preLHBL   = ($urandom_range(0, 7) != 0);
            preLVBL   = ($urandom_range(0, 15) != 0);
            step(model_addr(pxl, gfx_en, prio_swap, pal_bank), "random");
        end

        // PROM write between pixel enables, then a same-clock collision
        do_reset();
        set_in(tbl[0]);
        repeat (5) tick();
        check("prom_before_write", outs(), {model_rgb(8'h9D), 2'b11});
        prog_write(7'h25, 8'h3C);
        repeat (2) tick();
        check("prom_old_in_flight", outs(), {model_rgb(8'h9D), 2'b11});
        tick();
        check("prom_new_value", outs(), {model_rgb(8'h3C), 2'b11});
        tick_ex(1'b1, 7'h25, 8'hC3);
        mem_m[7'h25] = 8'hC3;
        repeat (2) tick();
        check("prom_collision_old", outs(), {model_rgb(8'h3C), 2'b11});
        tick();
        check("prom_after_collision", outs(), {model_rgb(8'hC3), 2'b11});

        // Asynchronous reset mid-frame, then recovery
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 14'h0);
        @(negedge clk);
        rst_n = 1'b1;
        preLHBL = 1'b0;
        repeat (2) tick();
        preLHBL = 1'b1;
        repeat (3) tick();
        check("post_reset_tick3", {red, green, blue}, 12'h0);
        tick();
        check("post_reset_tick4", outs(), {4'h6, 4'h0, 4'hF, 2'b11});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
